// File: rtl/pp_accum_sequencer.sv
// Partial-product accumulation sequencer: feeds a shared 41b+21b adder one term per cycle
// and registers its sum into a running accumulator, with start/done and valid/ready handshakes.
module pp_accum_sequencer #(
  parameter int ACC_W = 41,
  parameter int PP_W  = 21,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_terms,
  input  logic [ACC_W-1:0] init_val,
  input  logic             abort,
  input  logic             pp_valid,
  input  logic [PP_W-1:0]  pp_data,
  output logic             pp_ready,
  output logic [ACC_W-1:0] add_a,
  output logic [PP_W-1:0]  add_b,
  input  logic [ACC_W:0]   add_sum,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [ACC_W-1:0] result,
  output logic             overflow,
  output logic             busy
);

  // state | meaning
  // IDLE  | waiting for start
  // ACCUM | accepting one partial product per pp_valid cycle
  // DONE  | result held until res_ready
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic             ovf_q, ovf_d;
  logic             accept;

  assign accept    = (state_q == S_ACCUM) && pp_valid;
  assign pp_ready  = (state_q == S_ACCUM);
  assign res_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign add_a     = acc_q;
  assign add_b     = pp_data;
  assign result    = acc_q;
  assign overflow  = ovf_q;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    ovf_d   = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          acc_d   = init_val;
          rem_d   = num_terms;
          ovf_d   = 1'b0;
          state_d = (num_terms != '0) ? S_ACCUM : S_DONE;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          acc_d = add_sum[ACC_W-1:0];
          ovf_d = ovf_q | add_sum[ACC_W];
          rem_d = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything except the accumulator update of a same-cycle accept,
    // and also suppresses a start that would otherwise reload acc in IDLE.
    if (abort) begin
      state_d = S_IDLE;
      ovf_d   = 1'b0;
      if (state_q == S_IDLE) begin
        acc_d = acc_q;
        rem_d = rem_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: doc/pp_accum_sequencer.md
Name: pp_accum_sequencer

Overview:
- Multi-cycle controller that time-shares one 41-bit + 21-bit partial-product adder to accumulate a stream of 21-bit partial products into a 41-bit running sum.
- Sits between the partial-product generator and the multiplier result stage.
- Drives the shared adder's operands through ports and registers the adder's 42-bit sum.
- Exposes a start/done command interface and valid/ready streaming interfaces.

Parameters:
ACC_W, 41, accumulator / adder A-operand width
PP_W, 21, partial-product / adder B-operand width (must be <= ACC_W)
CNT_W, 6, width of term counter; maximum terms per job = 2**CNT_W - 1

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  single-cycle job request; honoured only in IDLE
num_terms  in  CNT_W  number of partial products in job, sampled with start
init_val  in  ACC_W  initial accumulator value, sampled with start
abort  in  1  synchronous cancel; returns to IDLE from any state
pp_valid  in  1  partial product available
pp_data  in  PP_W  partial product (unsigned)
pp_ready  out  1  sequencer accepts pp_data this cycle
add_a  out  ACC_W  to shared adder operand A (= acc register)
add_b  out  PP_W  to shared adder operand B (= pp_data)
add_sum  in  ACC_W+1  combinational sum from shared adder
res_valid  out  1  result available
res_ready  in  1  consumer accepts result
result  out  ACC_W  accumulated sum
overflow  out  1  sticky: any step produced add_sum[ACC_W]=1 during the job
busy  out  1  high in ACCUM or DONE

Behaviour:
- Reset (rst_n low, async): state=IDLE; acc=0, remaining=0, overflow=0; pp_ready=0, res_valid=0, busy=0. result reads 0.
- States: IDLE, ACCUM, DONE.
- IDLE:
  - start=1 and num_terms!=0 -> ACCUM next cycle; acc<=init_val, remaining<=num_terms, overflow<=0.
  - start=1 and num_terms==0 -> DONE directly; acc<=init_val, overflow<=0.
- ACCUM:
  - pp_ready=1. A term is accepted when pp_valid&&pp_ready.
  - On accept: acc<=add_sum[ACC_W-1:0]; overflow<=overflow|add_sum[ACC_W]; remaining<=remaining-1.
  - Accept with remaining==1 -> DONE next cycle.
  - Cycles with no pp_valid: hold all state.
  - Throughput: one term per cycle.
- DONE:
  - res_valid=1; result=acc; pp_ready=0.
  - res_valid&&res_ready -> IDLE; acc is retained for inspection.
- Latency: res_valid rises on the cycle after the last term is accepted (after start when num_terms==0).
- Adder interface: add_a=acc, add_b=pp_data, both combinational from registers/inputs. Adder semantics: add_sum = add_a + zero-extended add_b, result width ACC_W+1. Only add_sum captured on accept is used.
- On overflow, acc wraps to add_sum[ACC_W-1:0] (no saturation); the overflow flag records the event.
- start outside IDLE: ignored, no side effect. start and abort together in IDLE: abort wins, stay IDLE.
- abort=1 in any state: next state IDLE; res_valid and pp_ready drop next cycle. An accept in the abort cycle still updates acc but does not leave IDLE/ACCUM toward DONE. overflow is cleared.
- Asynchronous reset mid-job: immediate return to reset values; no result is produced.
- busy = (state!=IDLE).

Test Plan:
- Basic: start, num_terms=3, init_val=0; pp_data 5, 7, 9 back-to-back -> res_valid 1 cycle after 3rd accept; result=21, overflow=0.
- Bubbles/backpressure: num_terms=2, init_val=100; pp_valid gaps of 2 cycles; res_ready held low 3 cycles -> result stays 100+0x1FFFFF+1=0x200064 with res_valid high until res_ready; then IDLE.
- Overflow: init_val=0x1FFFFFFFFFF (all ones), num_terms=1, pp_data=2 -> result=1, overflow=1. A following job with no overflow -> overflow=0.
- Zero terms: start with num_terms=0, init_val=0x123 -> res_valid next cycle, result=0x123, no pp_ready pulse.
- Abort: num_terms=4, abort after 2 accepts -> IDLE next cycle, res_valid never rises; start ignored while in ACCUM/DONE.
- Async reset: assert rst_n=0 mid-ACCUM, between clock edges -> all outputs at reset values immediately.
